bullet_phase_ctrl: RTL and testbench
====================================

Name: bullet_phase_ctrl

Overview:
Sequences one enemy attack phase for the bullet store. It loads the initial bullet set, paces bullet movement from the VGA frame tick, and scans every bullet slot against the collision checker once per movement step. It then commits the surviving-bullet mask back to the store and ends the phase on timeout or when every bullet is gone. It sits between the game FSM (start/done), the VGA timing (frame_tick), the collision unit and the bullet store (run/step/scan index/alive mask/commit).

Parameters:
N_BULLETS, 3, number of bullet slots sequenced (1..8)
IDX_W, 3, width of slot index and alive mask
MOVE_DIV, 2, frame ticks per movement step (>=1)
PHASE_FRAMES, 300, frame ticks before the phase times out (1..65535)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse from game FSM; begins a phase (ignored unless IDLE)
frame_tick  in  1  one-cycle pulse per VGA frame
hit  in  1  collision result for slot scan_index, valid same cycle while scan_valid=1
is_run  out  1  high during a phase; low forces bullet store to reload initial set
step  out  1  one-cycle pulse: bullet store advances positions
scan_index  out  IDX_W  slot currently presented to collision unit
scan_valid  out  1  scan_index is being sampled this cycle
alive_mask  out  IDX_W  bit i = slot i still rendered
commit  out  1  one-cycle pulse: store latches alive_mask into render bits
hit_count  out  4  hits this phase, saturates at 15
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when phase ends

Behaviour:
- Reset (async, any state): state=IDLE; is_run=0, step=0, scan_valid=0, scan_index=0, commit=0, done=0, busy=0, hit_count=0, alive_mask=all ones (low N_BULLETS bits), frame and divider counters=0.
- States: IDLE, LOAD, RUN, SCAN, COMMIT, FINISH.
- IDLE: is_run=0. On start -> LOAD.
- LOAD: 1 cycle; is_run stays 0 so the store reloads; clear hit_count and counters; alive_mask=all ones -> RUN.
- RUN: is_run=1. On each frame_tick: frame_cnt++ and div_cnt++. When div_cnt reaches MOVE_DIV, div_cnt=0, step pulses in the same cycle, then -> SCAN with scan_index=0.
- If frame_cnt reaches PHASE_FRAMES on a tick, -> FINISH. Timeout wins over a step in the same tick, and no step is issued.
- SCAN: scan_valid=1 for exactly N_BULLETS consecutive cycles, indices 0..N_BULLETS-1. Each cycle, if hit=1 and alive_mask[scan_index]=1: clear that bit and increment hit_count (saturating). A hit on an already-dead slot is ignored. After the last index -> COMMIT.
- frame_tick arriving during SCAN/COMMIT is still counted, so no frame is lost. A step due in that window is deferred to the first RUN cycle.
- COMMIT: commit=1 for 1 cycle with the updated mask. If alive_mask==0 -> FINISH, else -> RUN.
- FINISH: done=1 for 1 cycle; is_run stays 1 so the final positions and mask remain displayed -> IDLE. alive_mask and hit_count hold until the next LOAD.
- Latency: start to first is_run=1 is 2 cycles. A step pulse is followed by scan_index 0 on the next cycle, and commit follows N_BULLETS+1 cycles after step.
- Mask bits at or above N_BULLETS are tied 0.
- All outputs are registered. Counters widths: frame_cnt 16 bits, div_cnt ceil(log2(MOVE_DIV+1)) bits.
- start while busy is ignored; there is no restart mid-phase.
- Reset asserted mid-SCAN returns to IDLE immediately, with no commit or done pulse.

Decomposition:
- Shared package bullet_pkg holds: state enum encoding, IDX_W, N_BULLETS default, and the 36-bit bullet word field offsets (y, x, h, w, color, render) used by the store and the collision unit.
- One natural sub-module: phase_timer, which holds the frame and divider counters and emits step_due/timeout; the FSM stays in the top.

Test Plan:
1. Reset, start pulse, MOVE_DIV=2, 4 frame_ticks -> is_run rises 2 cycles after start; step pulses on ticks 2 and 4; each step is followed by scan_index 0,1,2 with scan_valid, then commit; alive_mask=3'b111.
2. hit=1 only when scan_index=1 during the first scan -> commit carries alive_mask=3'b101, hit_count=1. Same slot hit again on the next scan -> mask unchanged, hit_count=1.
3. Hits on all three slots across scans -> the commit with mask 3'b000 is followed by done the next cycle, then IDLE; hit_count=3.
4. PHASE_FRAMES=5, no hits -> done on the cycle after the 5th tick; no step on tick 5 (tick 4 step still occurs); busy falls after done.
5. frame_tick coincident with the first SCAN cycle, MOVE_DIV=1 -> the tick is counted, and a deferred step pulses on the first RUN cycle after commit.
6. Assert reset during SCAN -> all outputs reach reset values without a clock edge; a start pulse during RUN is ignored (no LOAD, hit_count unchanged).

Source files
------------

// File: rtl/bullet_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bullet_pkg
// Brief   : Shared types and constants for the enemy bullet subsystem.
// Revision: 1.0 - initial release
// ============================================================================
package bullet_pkg;

    localparam int BULLET_IDX_W     = 3;
    localparam int BULLET_N_DEFAULT = 3;

    // 36-bit bullet word: {render, color[4:0], w[4:0], h[4:0], x[9:0], y[9:0]}
    localparam int BW_WIDTH      = 36;
    localparam int BW_Y_LSB      = 0;
    localparam int BW_Y_W        = 10;
    localparam int BW_X_LSB      = 10;
    localparam int BW_X_W        = 10;
    localparam int BW_H_LSB      = 20;
    localparam int BW_H_W        = 5;
    localparam int BW_W_LSB      = 25;
    localparam int BW_W_W        = 5;
    localparam int BW_COLOR_LSB  = 30;
    localparam int BW_COLOR_W    = 5;
    localparam int BW_RENDER_BIT = 35;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_SCAN   = 3'd3,
        ST_COMMIT = 3'd4,
        ST_FINISH = 3'd5
    } phase_state_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module  : phase_timer
// Brief   : Frame and movement-divider counters; flags step_due / timeout.
// Revision: 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int MOVE_DIV     = 2,
    parameter int PHASE_FRAMES = 300
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    input  logic tick,
    input  logic step_ack,
    output logic step_due,
    output logic timeout
);

    localparam int c_div_w = $clog2(MOVE_DIV + 1);

    logic [15:0]        r_frame_cnt;
    logic [c_div_w-1:0] r_div_cnt;
    logic               r_pending;
    logic               r_timeout;

    logic w_tick_en;
    logic w_div_wrap;
    logic w_frame_end;

    assign w_tick_en   = count_en & tick;
    assign w_div_wrap  = (r_div_cnt == c_div_w'(MOVE_DIV - 1));
    assign w_frame_end = (r_frame_cnt == 16'(PHASE_FRAMES - 1));

    // Both flags are live in the tick cycle and latched so that ticks seen
    // while the FSM is busy scanning are acted on later.
    assign step_due = r_pending | (w_tick_en & w_div_wrap);
    assign timeout  = r_timeout | (w_tick_en & w_frame_end);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_div_cnt   <= '0;
            r_pending   <= 1'b0;
            r_timeout   <= 1'b0;
        end else if (clear) begin
            r_frame_cnt <= '0;
            r_div_cnt   <= '0;
            r_pending   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_tick_en) begin
                if (r_frame_cnt != 16'hFFFF) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
                if (w_frame_end) begin
                    r_timeout <= 1'b1;
                end
                r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + c_div_w'(1);
            end
            r_pending <= step_due & ~step_ack;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bullet_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : bullet_phase_ctrl
// Brief   : Sequences one enemy attack phase: load, move, collide, commit.
// Revision: 1.0 - initial release
// ============================================================================
module bullet_phase_ctrl
    import bullet_pkg::*;
#(
    parameter int N_BULLETS    = BULLET_N_DEFAULT,
    parameter int IDX_W        = BULLET_IDX_W,
    parameter int MOVE_DIV     = 2,
    parameter int PHASE_FRAMES = 300
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             frame_tick,
    input  logic             hit,
    output logic             is_run,
    output logic             step,
    output logic [IDX_W-1:0] scan_index,
    output logic             scan_valid,
    output logic [IDX_W-1:0] alive_mask,
    output logic             commit,
    output logic [3:0]       hit_count,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] c_full_mask = IDX_W'((1 << N_BULLETS) - 1);
    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(N_BULLETS - 1);

    phase_state_t     r_state;
    logic             r_is_run;
    logic             r_step;
    logic [IDX_W-1:0] r_scan_index;
    logic             r_scan_valid;
    logic [IDX_W-1:0] r_alive_mask;
    logic             r_commit;
    logic [3:0]       r_hit_count;
    logic             r_busy;
    logic             r_done;

    logic             w_step_due;
    logic             w_timeout;
    logic             w_step_ack;
    logic             w_count_en;
    logic             w_clear;
    logic [IDX_W-1:0] w_slot;
    logic             w_slot_live;

    assign w_clear    = (r_state == ST_LOAD);
    assign w_count_en = (r_state == ST_RUN) || (r_state == ST_SCAN) ||
                        (r_state == ST_COMMIT);

    // A step is taken either from RUN or on the way out of COMMIT (deferred).
    assign w_step_ack = w_step_due & ~w_timeout &
                        (((r_state == ST_RUN) & ~r_step) |
                         ((r_state == ST_COMMIT) & (r_alive_mask != '0)));

    assign w_slot      = IDX_W'(1) << r_scan_index;
    assign w_slot_live = |(r_alive_mask & w_slot);

    phase_timer #(
        .MOVE_DIV     (MOVE_DIV),
        .PHASE_FRAMES (PHASE_FRAMES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_clear),
        .count_en (w_count_en),
        .tick     (frame_tick),
        .step_ack (w_step_ack),
        .step_due (w_step_due),
        .timeout  (w_timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_is_run     <= 1'b0;
            r_step       <= 1'b0;
            r_scan_index <= '0;
            r_scan_valid <= 1'b0;
            r_alive_mask <= c_full_mask;
            r_commit     <= 1'b0;
            r_hit_count  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_step   <= 1'b0;
            r_commit <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_LOAD;
                        r_busy       <= 1'b1;
                        r_hit_count  <= '0;
                        r_alive_mask <= c_full_mask;
                    end
                end
                ST_LOAD: begin
                    r_state  <= ST_RUN;
                    r_is_run <= 1'b1;
                end
                ST_RUN: begin
                    // The step pulse cycle always proceeds into its scan.
                    if (r_step) begin
                        r_state      <= ST_SCAN;
                        r_scan_valid <= 1'b1;
                        r_scan_index <= '0;
                    end else if (w_timeout) begin
                        r_state <= ST_FINISH;
                        r_done  <= 1'b1;
                    end else if (w_step_due) begin
                        r_step <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (hit && w_slot_live) begin
                        r_alive_mask <= r_alive_mask & ~w_slot;
                        r_hit_count  <= sat_inc4(r_hit_count);
                    end
                    if (r_scan_index == c_last_idx) begin
                        r_state      <= ST_COMMIT;
                        r_scan_valid <= 1'b0;
                        r_scan_index <= '0;
                        r_commit     <= 1'b1;
                    end else begin
                        r_scan_index <= r_scan_index + IDX_W'(1);
                    end
                end
                ST_COMMIT: begin
                    if ((r_alive_mask == '0) || w_timeout) begin
                        r_state <= ST_FINISH;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                        r_step  <= w_step_due;
                    end
                end
                ST_FINISH: begin
                    r_state  <= ST_IDLE;
                    r_is_run <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign is_run     = r_is_run;
    assign step       = r_step;
    assign scan_index = r_scan_index;
    assign scan_valid = r_scan_valid;
    assign alive_mask = r_alive_mask;
    assign commit     = r_commit;
    assign hit_count  = r_hit_count;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bullet_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_bullet_phase_ctrl
// Brief   : Scoreboard bench: timed expected events vs. observed DUT pulses.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bullet_phase_ctrl;

    localparam int c_n = 3;

    logic       clk;
    logic       reset;
    logic       start;
    logic       frame_tick;
    logic       hit;
    logic       is_run;
    logic       step;
    logic [2:0] scan_index;
    logic       scan_valid;
    logic [2:0] alive_mask;
    logic       commit;
    logic [3:0] hit_count;
    logic       busy;
    logic       done;

    bullet_phase_ctrl #(
        .N_BULLETS    (c_n),
        .IDX_W        (3),
        .MOVE_DIV     (2),
        .PHASE_FRAMES (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .frame_tick (frame_tick),
        .hit        (hit),
        .is_run     (is_run),
        .step       (step),
        .scan_index (scan_index),
        .scan_valid (scan_valid),
        .alive_mask (alive_mask),
        .commit     (commit),
        .hit_count  (hit_count),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        int kind;
        int cycle;
        int data;
        int hc;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            0:       return "step";
            1:       return "scan";
            2:       return "commit";
            default: return "done";
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int k, input int c, input int d, input int h);
        ev_t e;
        e.kind  = k;
        e.cycle = c;
        e.data  = d;
        e.hc    = h;
        exp_q.push_back(e);
    endtask

    // Step at sc, scans sc+1..sc+N, commit N+1 cycles after the step.
    task automatic exp_burst(input int sc, input int mask, input int h);
        push(0, sc, -1, -1);
        for (int i = 0; i < c_n; i++) push(1, sc + 1 + i, i, -1);
        push(2, sc + c_n + 1, mask, h);
    endtask

    task automatic observe(input int k, input int d, input int h);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL ev_unexpected: got %s cycle=%0d data=%0d hc=%0d, expected none",
                     kname(k), cyc, d, h);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k || e.cycle != cyc || (e.data >= 0 && e.data != d) ||
            (e.hc >= 0 && e.hc != h)) begin
            bad++;
            $display("FAIL ev_%s: got %s cycle=%0d data=%0d hc=%0d, expected %s cycle=%0d data=%0d hc=%0d",
                     kname(e.kind), kname(k), cyc, d, h, kname(e.kind), e.cycle, e.data, e.hc);
        end
    endtask

    always @(negedge clk) begin
        if (step)       observe(0, 0, int'(hit_count));
        if (scan_valid) observe(1, int'(scan_index), int'(hit_count));
        if (commit)     observe(2, int'(alive_mask), int'(hit_count));
        if (done)       observe(3, int'(alive_mask), int'(hit_count));
    end

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_at(input int c);
        at_cycle(c);
        @(negedge clk);
    endtask

    // Drive one-cycle pulses during cycle c.
    task automatic drive(input int c, input logic t, input logic h, input logic s);
        at_cycle(c);
        frame_tick = t;
        hit        = h;
        start      = s;
        at_cycle(c + 1);
        frame_tick = 1'b0;
        hit        = 1'b0;
        start      = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        frame_tick = 1'b0;
        hit        = 1'b0;

        check_at(1);
        chk("rst_ctrl", {is_run, step, scan_valid, commit, done, busy}, 0);
        chk("rst_scan_index", int'(scan_index), 0);
        chk("rst_alive_mask", int'(alive_mask), 7);
        chk("rst_hit_count", int'(hit_count), 0);
        at_cycle(2);
        reset = 1'b0;

        // Phase A: two steps, repeated hit on slot 1, timeout on tick 5.
        exp_burst(19, 3'b101, 1);
        exp_burst(31, 3'b101, 1);
        push(3, 39, 3'b101, 1);
        drive(10, 1'b0, 1'b0, 1'b1);
        check_at(11);
        chk("load_is_run", int'(is_run), 0);
        chk("load_busy", int'(busy), 1);
        check_at(12);
        chk("run_is_run", int'(is_run), 1);
        drive(14, 1'b1, 1'b0, 1'b0);
        drive(18, 1'b1, 1'b0, 1'b0);
        drive(21, 1'b0, 1'b1, 1'b0);
        drive(26, 1'b1, 1'b0, 1'b0);
        drive(30, 1'b1, 1'b0, 1'b0);
        drive(33, 1'b0, 1'b1, 1'b0);
        drive(38, 1'b1, 1'b0, 1'b0);
        check_at(39);
        chk("finish_busy", int'(busy), 1);
        chk("finish_is_run", int'(is_run), 1);
        check_at(40);
        chk("idle_busy", int'(busy), 0);
        chk("idle_is_run", int'(is_run), 0);
        chk("idle_hold_mask", int'(alive_mask), 5);

        // Phase B: ignored start, deferred step, all slots destroyed.
        exp_burst(61, 3'b010, 2);
        exp_burst(66, 3'b000, 3);
        push(3, 71, 0, 3);
        drive(50, 1'b0, 1'b0, 1'b1);
        check_at(51);
        chk("reload_hit_count", int'(hit_count), 0);
        chk("reload_mask", int'(alive_mask), 7);
        drive(54, 1'b0, 1'b0, 1'b1);
        check_at(55);
        chk("restart_ignored", int'(is_run), 1);
        drive(56, 1'b1, 1'b0, 1'b0);
        drive(60, 1'b1, 1'b0, 1'b0);
        drive(61, 1'b1, 1'b0, 1'b0);
        drive(62, 1'b1, 1'b1, 1'b0);
        drive(64, 1'b0, 1'b1, 1'b0);
        drive(68, 1'b0, 1'b1, 1'b0);
        check_at(72);
        chk("wipe_busy", int'(busy), 0);
        chk("wipe_hit_count", int'(hit_count), 3);
        chk("wipe_mask", int'(alive_mask), 0);

        // Phase C: asynchronous reset in the middle of a scan.
        push(0, 89, -1, -1);
        push(1, 90, 0, -1);
        drive(80, 1'b0, 1'b0, 1'b1);
        drive(84, 1'b1, 1'b0, 1'b0);
        drive(88, 1'b1, 1'b0, 1'b0);
        drive(90, 1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_ctrl", {is_run, step, scan_valid, commit, done, busy}, 0);
        chk("async_scan_index", int'(scan_index), 0);
        chk("async_mask", int'(alive_mask), 7);
        chk("async_hit_count", int'(hit_count), 0);
        at_cycle(93);
        reset = 1'b0;

        check_at(100);
        chk("queue_drain", exp_q.size(), 0);
        chk("post_reset_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
